// File: rtl/stavka_a.sv
// ---------------------------------------------------------------------------
// stavka_a -- registered parity generator
//
// Appends a parity bit to a 7-bit data word and registers the result.
// The control input selects the parity mode:
//   control = 0 : even parity (data_out holds an even number of 1s)
//   control = 1 : odd parity  (data_out holds an odd number of 1s)
//
// Ports
//   clk      in   1  rising-edge clock for all state
//   rst_n    in   1  synchronous active-low reset; clears data_out to 8'h00
//   data_in  in   7  data word to protect
//   control  in   1  parity mode select (0 = even, 1 = odd)
//   data_out out  8  registered {data_in, parity}, one cycle after sampling
// ---------------------------------------------------------------------------
module stavka_a (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] data_in,
  input  logic       control,
  output logic [7:0] data_out
);

  // XOR of the word gives the bit that makes the total even; folding in the
  // mode bit flips it to odd parity when control is high.
  function automatic logic parity_bit(input logic [6:0] word, input logic mode);
    parity_bit = (^word) ^ mode;
  endfunction

  logic [7:0] data_p0;

  // Stage p0: single output register. Reset clears the whole word, so a
  // freshly reset block presents 8'h00 rather than a stale value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_p0 <= 8'h00;
    end else begin
      data_p0 <= {data_in, parity_bit(data_in, control)};
    end
  end

  assign data_out = data_p0;

endmodule

// File: tb/tb_stavka_a.sv
// ---------------------------------------------------------------------------
// tb_stavka_a -- self-checking bench for stavka_a
//
// Stimulus is applied 1 time unit after each rising edge; the expected word
// for that stimulus is pushed to a scoreboard queue and popped once the
// following rising edge has captured it.
// ---------------------------------------------------------------------------
module tb_stavka_a;

  logic       clk;
  logic       rst_n;
  logic [6:0] data_in;
  logic       control;
  logic [7:0] data_out;

  int compared;
  int mismatched;

  logic [7:0] sb[$];
  logic [7:0] exp_v;

  stavka_a dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .control  (control),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: choose the parity bit so the count of ones in the full
  // 8-bit word is even (control=0) or odd (control=1).
  function automatic logic [7:0] model(input logic [6:0] d, input logic c);
    int ones;
    logic p;
    ones = 0;
    for (int k = 0; k < 7; k++) if (d[k]) ones++;
    if (c) p = (ones % 2 == 0) ? 1'b1 : 1'b0;
    else   p = (ones % 2 == 1) ? 1'b1 : 1'b0;
    return {d, p};
  endfunction

  // Drive one cycle of stimulus, record its expectation, and move to just
  // after the capturing edge.
  task automatic drive(input logic [6:0] d, input logic c, input logic r);
    data_in = d;
    control = c;
    rst_n   = r;
    sb.push_back(r ? model(d, c) : 8'h00);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // prior activity with reset released, then reset with all-ones inputs
    drive(7'h2A, 1'b0, 1'b1);
    void'(sb.pop_front());
    drive(7'h7F, 1'b1, 1'b0);
    compared++;
    exp_v = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    if (data_out !== exp_v || exp_v !== 8'h00) begin
      mismatched++;
      $display("FAIL reset: data_out=%h expected=%h", data_out, 8'h00);
    end
    // first edge after release registers inputs normally
    drive(7'h7F, 1'b1, 1'b1);
    compared++;
    exp_v = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    if (data_out !== exp_v || data_out !== 8'hFE) begin
      mismatched++;
      $display("FAIL reset_release: data_out=%h expected=%h", data_out, 8'hFE);
    end
  endtask

  task automatic test_parity();
    logic [6:0] din [5] = '{7'b1010101, 7'b0000001, 7'b1010101, 7'h7F, 7'h00};
    logic       ctl [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] want[5] = '{8'b10101010, 8'b00000011, 8'b10101011, 8'hFE, 8'h01};
    for (int i = 0; i < 5; i++) begin
      drive(din[i], ctl[i], 1'b1);
      compared++;
      exp_v = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      if (data_out !== exp_v || data_out !== want[i]) begin
        mismatched++;
        $display("FAIL parity_vec%0d: data_out=%h expected=%h", i, data_out, want[i]);
      end
    end
  endtask

  task automatic test_mode_toggle();
    logic [7:0] want[2] = '{8'hFF, 8'hFE};
    for (int i = 0; i < 2; i++) begin
      drive(7'h7F, i[0], 1'b1);
      compared++;
      exp_v = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      if (data_out !== exp_v || data_out !== want[i]) begin
        mismatched++;
        $display("FAIL mode_toggle%0d: data_out=%h expected=%h", i, data_out, want[i]);
      end
    end
  endtask

  task automatic test_sweep_with_reset();
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = i[7:0];
      if (i == 128) begin
        // mid-stream reset for exactly one edge
        drive(v[7:1], v[0], 1'b0);
        compared++;
        exp_v = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        if (data_out !== exp_v) begin
          mismatched++;
          $display("FAIL sweep_reset: data_out=%h expected=%h", data_out, exp_v);
        end
      end
      drive(v[7:1], v[0], 1'b1);
      compared++;
      exp_v = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      if (data_out !== exp_v) begin
        mismatched++;
        $display("FAIL sweep_i%0d: data_out=%h expected=%h", i, data_out, exp_v);
      end
    end
  endtask

  task automatic test_between_edges();
    logic [7:0] held;
    drive(7'b1010101, 1'b0, 1'b1);
    held = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    // input wiggles and a short reset pulse that does not span an edge
    #1 data_in = 7'h7F; control = 1'b1;
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    compared++;
    if (data_out !== held || held !== 8'hAA) begin
      mismatched++;
      $display("FAIL between_edges: data_out=%h expected=%h", data_out, 8'hAA);
    end
    // what is present at the next edge is what gets captured
    drive(7'h00, 1'b0, 1'b1);
    compared++;
    exp_v = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    if (data_out !== exp_v || data_out !== 8'h00) begin
      mismatched++;
      $display("FAIL after_glitch: data_out=%h expected=%h", data_out, 8'h00);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    data_in    = 7'h00;
    control    = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_parity();
    test_mode_toggle();
    test_sweep_with_reset();
    test_between_edges();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
